// File: rtl/uart_rx_fifo_port.sv
// uart_rx_fifo_port: memory-mapped UART receiver with a byte FIFO.
// Bytes are deserialized from rx (8N1, LSB first), queued in a circular
// buffer, and popped by loads from RXDATA. STATUS exposes occupancy and
// sticky error flags; CONTROL clears the flags and flushes the FIFO.
module uart_rx_fifo_port #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Address,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    input  logic             Select,
    input  logic             Write,
    input  logic             Read,
    input  logic             rx,
    output logic [CNT_W-1:0] rx_level
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_RSVD} reg_t;

    // Receiver state
    logic             rx_meta, rx_s;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             frame_err;

    // FIFO and flag state
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overrun_q, framing_err_q;

    // Bus decode
    reg_t reg_sel;
    logic empty, full, pop, ctrl_wr, flush, wr_en, rd_en, overrun_set;
    logic unused_bits;

    assign reg_sel     = reg_t'(Address[3:2]);
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_FULL);
    assign pop         = Select & Read & (reg_sel == REG_DATA) & ~empty;
    assign ctrl_wr     = Select & Write & (reg_sel == REG_CTRL);
    assign flush       = ctrl_wr & DataIn[2];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_en       = push & ~flush & (~full | pop);
    assign rd_en       = pop & ~flush;
    assign overrun_set = push & ~flush & full & ~pop;
    assign rx_level    = count_q;
    assign unused_bits = ^{Address[31:4], Address[1:0], DataIn[31:3]};

    // Two-flop synchronizer for the asynchronous rx pin (idles high).
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, which makes the two stages a real pipeline.
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Receiver FSM next-state: start validation at mid-bit, data sampling, stop check.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    div_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (div_q == HALF_LAST) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        div_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (div_q == BIT_LAST) begin
                    div_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (div_q == BIT_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        push = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the byte array has no reset; its contents are only visible
        // through count-qualified reads, so stale data is never observed.
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q     <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            overrun_q     <= overrun_set | (overrun_q & ~(ctrl_wr & DataIn[0]));
            framing_err_q <= frame_err | (framing_err_q & ~(ctrl_wr & DataIn[1]));
        end
    end

    // Combinational read mux for single-cycle loads.
    always_comb begin
        DataOut = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!empty) begin
                    DataOut = {24'b0, mem[rd_ptr_q]};
                end
            end
            REG_STATUS: begin
                DataOut[0]           = ~empty;
                DataOut[1]           = full;
                DataOut[2]           = overrun_q;
                DataOut[3]           = framing_err_q;
                DataOut[8 +: CNT_W]  = count_q;
            end
            default: DataOut = '0;
        endcase
    end

endmodule

// File: doc/uart_rx_fifo_port.md
Name: uart_rx_fifo_port

Overview:
- Memory-mapped UART receive peripheral with an on-chip receive FIFO, occupying a select line on the singlecycle memory map decoder.
- Deserializes the board rx pin, buffers bytes, and lets the core poll status and pop bytes with lw/sw.
- The FIFO decouples the core from byte timing, so a multi-byte command arriving during a long factorial loop is not lost.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- FIFO_DEPTH, 8, number of byte entries; must be a power of two, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- Address  input  32  byte address from the decoder; only Address[3:2] is decoded.
- DataIn  input  32  write data from the core.
- DataOut  output  32  combinational read data.
- Select  input  1  device chip-select from the decoder.
- Write  input  1  store strobe, qualified by Select.
- Read  input  1  load strobe, qualified by Select.
- rx  input  1  asynchronous serial input, idle high.
- rx_level  output  CNT_W  current FIFO occupancy, for display or debug.

Behaviour:
- **Reset:** all state clears asynchronously on rst=1.
  - Synchronizer flops reset to 1.
  - FSM goes to IDLE; divider, bit index and shift register go to 0.
  - FIFO pointers and count go to 0; overrun and framing_err go to 0.
  - rx_level resets to 0. DataOut is combinational and reads as 0 for an empty FIFO.
- **Synchronizer:** rx passes through a 2-FF synchronizer (rx_s). All FSM decisions use rx_s.
- **Bit timing:** CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, using integer truncation. HALF = CLKS_PER_BIT/2.
- **FSM states:**
  - IDLE: on rx_s=0, load divider=0 and go to START.
  - START: count to HALF-1.
    - If rx_s=0, go to DATA with bit index 0 and divider cleared.
    - Otherwise it was a glitch; return to IDLE.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit index], LSB first.
    - After bit 7, go to STOP; otherwise increment the index.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - If 1, issue a one-cycle push of shift[7:0].
    - If 0, set framing_err (sticky) and discard the byte.
    - Go to IDLE in both cases.
- **Register map (Address[3:2]):**
  - 00 RXDATA:
    - Read returns {24'b0, head byte}, or 0 when empty.
    - A pop occurs on the clock edge when Select & Read & Address[3:2]==00 & not empty.
  - 01 STATUS, read-only:
    - Bit0 not_empty, bit1 full, bit2 overrun, bit3 framing_err.
    - Bits[8+CNT_W-1:8] hold the count; all other bits are 0.
    - Reads have no side effect.
  - 10 CONTROL, write-only (reads return 0). On Select & Write:
    - DataIn[0]=1 clears overrun.
    - DataIn[1]=1 clears framing_err.
    - DataIn[2]=1 flushes the FIFO (pointers and count to 0).
  - 11 is reserved: reads return 0 and writes are ignored.
  - Write to RXDATA or STATUS is ignored. Read and Write asserted together: both actions are performed.
- **FIFO:**
  - Circular buffer; pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally from FIFO_DEPTH-1 to 0.
  - Push when full: the byte is dropped, overrun is set, and pointers and count are unchanged.
  - Push and pop in the same cycle:
    - Not empty: both happen and count is unchanged. This holds when full too, because the pop frees a slot, so no overrun.
    - Empty: the pop is ignored and the push proceeds.
  - Flush and push in the same cycle: flush wins and the byte is discarded.
  - Flush and pop in the same cycle: flush wins.
  - Clear and set of a sticky flag in the same cycle: set wins.
- **Read timing:** DataOut is valid combinationally in the same cycle as Address and Select, for singlecycle lw. A pop takes effect after the edge.
- **Reset mid-frame:** the partial byte is lost. After release the FSM waits in IDLE for the next falling edge.
- rx_level equals count.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so 10 clks/bit; FIFO_DEPTH=8):
- Reset check: assert rst mid-run -> rx_level=0; STATUS=0x0000_0000; RXDATA=0.
- Single byte: send frame 0x41 -> push about 95 clks after the start edge; STATUS=0x0000_0101. Pop RXDATA -> 0x0000_0041, then STATUS=0x0.
- Ordering and wrap: send 0x01..0x08 -> full, STATUS=0x0000_0803. Pop 3, send 0x09..0x0B, pop 8 -> 0x04..0x0B in order.
- Overrun: fill 8, then send 0x55 -> count stays 8, bit2 set, head still 0x01. Write CONTROL=0x1 -> bit2 clears.
- Framing and glitch:
  - Send 0xA5 with stop bit 0 -> no push; bit3 set.
  - A 3-clk low pulse on rx -> returns to IDLE with no push.
- Simultaneous events:
  - Pop on the exact push cycle with count=2 -> count stays 2.
  - Same with count=0 -> count becomes 1 and DataOut shows the new byte.
  - Flush on the push cycle -> count=0.
